// File: rtl/fpu_exp_pkg.sv
// Shared definitions for the FPU exponent datapath: mode encodings,
// range-check flag bundle and the IEEE bias helper.
package fpu_exp_pkg;

    typedef enum logic [1:0] {
        EXP_ADD = 2'b00,   // A + B
        EXP_SUB = 2'b01,   // A - B
        EXP_MUL = 2'b10,   // A + B - BIAS
        EXP_DIV = 2'b11    // A - B + BIAS
    } exp_mode_t;

    typedef struct packed {
        logic ovf;
        logic unf;
    } exp_flags_t;

    function automatic int default_bias(input int ew);
        return (1 << (ew - 1)) - 1;
    endfunction

endpackage

// File: rtl/exp_range_check.sv
// Signed range check of a bias-corrected exponent: overflow at or above the
// all-ones (reserved) code, underflow at or below zero.
module exp_range_check
    import fpu_exp_pkg::*;
#(
    parameter int EW = 8
) (
    input  logic signed [EW+1:0] value,
    output exp_flags_t           flags
);

    localparam int RW = EW + 2;
    localparam logic signed [RW-1:0] MAX_EXP = RW'((1 << EW) - 1);
    localparam logic signed [RW-1:0] ZERO    = '0;

    assign flags.ovf = (value >= MAX_EXP);
    assign flags.unf = (value <= ZERO);

endmodule

// File: rtl/exp_operation_pipe.sv
// Two-stage elastic exponent add/subtract unit with bias correction,
// optional saturation and sticky exception flags.
module exp_operation_pipe
    import fpu_exp_pkg::*;
#(
    parameter int EW   = 8,
    parameter int BIAS = default_bias(EW),
    parameter bit SAT  = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [1:0]    op_mode_i,
    input  logic [EW-1:0] Data_A_i,
    input  logic [EW-1:0] Data_B_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [EW-1:0] Data_Result_o,
    output logic          Overflow_flag_o,
    output logic          Underflow_flag_o,
    input  logic          sticky_clr_i,
    output logic          Sticky_ovf_o,
    output logic          Sticky_unf_o
);

    localparam int RW = EW + 2;
    localparam logic signed [RW-1:0] BIAS_W = RW'(BIAS);

    logic [2:1]             vld_pipe;
    logic                   s2_load;
    logic                   handoff;
    exp_mode_t              in_mode;
    logic [RW-1:0]          a_ext;
    logic [RW-1:0]          b_ext;
    logic signed [RW-1:0]   raw_next;
    logic signed [RW-1:0]   s1_raw;
    exp_mode_t              s1_mode;
    logic signed [RW-1:0]   corrected;
    exp_flags_t             flags;
    logic [EW-1:0]          result_next;

    assign s2_load     = !vld_pipe[2] || out_ready_i;
    assign in_ready_o  = !vld_pipe[1] || s2_load;
    assign out_valid_o = vld_pipe[2];
    assign handoff     = vld_pipe[2] && out_ready_i;

    // Zero-extend by two bits so A+B cannot wrap and A-B keeps its sign.
    assign in_mode  = exp_mode_t'(op_mode_i);
    assign a_ext    = {2'b00, Data_A_i};
    assign b_ext    = {2'b00, Data_B_i};
    assign raw_next = (in_mode == EXP_SUB || in_mode == EXP_DIV) ? a_ext - b_ext
                                                                 : a_ext + b_ext;

    always_comb begin
        corrected = s1_raw;
        case (s1_mode)
            EXP_MUL: corrected = s1_raw - BIAS_W;
            EXP_DIV: corrected = s1_raw + BIAS_W;
            default: corrected = s1_raw;
        endcase
    end

    exp_range_check #(.EW(EW)) u_range (
        .value (corrected),
        .flags (flags)
    );

    always_comb begin
        result_next = corrected[EW-1:0];
        if (SAT && flags.ovf)
            result_next = '1;
        else if (SAT && flags.unf)
            result_next = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe         <= '0;
            s1_raw           <= '0;
            s1_mode          <= EXP_ADD;
            Data_Result_o    <= '0;
            Overflow_flag_o  <= 1'b0;
            Underflow_flag_o <= 1'b0;
            Sticky_ovf_o     <= 1'b0;
            Sticky_unf_o     <= 1'b0;
        end else begin
            if (in_ready_o) begin
                vld_pipe[1] <= in_valid_i;
                if (in_valid_i) begin
                    s1_raw  <= raw_next;
                    s1_mode <= in_mode;
                end
            end
            if (s2_load) begin
                vld_pipe[2] <= vld_pipe[1];
                if (vld_pipe[1]) begin
                    Data_Result_o    <= result_next;
                    Overflow_flag_o  <= flags.ovf;
                    Underflow_flag_o <= flags.unf;
                end
            end
            // A flag handed off in the clearing cycle still survives.
            Sticky_ovf_o <= (handoff && Overflow_flag_o)  || (Sticky_ovf_o && !sticky_clr_i);
            Sticky_unf_o <= (handoff && Underflow_flag_o) || (Sticky_unf_o && !sticky_clr_i);
        end
    end

endmodule

// File: tb/tb_exp_operation_pipe.sv
// Scoreboard bench: stimulus pushes hand-computed expectations, a monitor pops
// and compares on every handoff; a SAT=0 twin shares the same stimulus.
module tb_exp_operation_pipe;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b1;
    logic       sticky_clr = 1'b0;
    logic [1:0] op_mode = 2'b00;
    logic [7:0] a = 8'd0;
    logic [7:0] b = 8'd0;

    logic       in_ready, out_valid, ovf, unf, s_ovf, s_unf;
    logic [7:0] res;
    logic       ns_in_ready, ns_out_valid, ns_ovf, ns_unf, ns_s_ovf, ns_s_unf;
    logic [7:0] ns_res;

    exp_operation_pipe #(.EW(8), .BIAS(127), .SAT(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .op_mode_i(op_mode), .Data_A_i(a), .Data_B_i(b),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .Data_Result_o(res),
        .Overflow_flag_o(ovf), .Underflow_flag_o(unf), .sticky_clr_i(sticky_clr),
        .Sticky_ovf_o(s_ovf), .Sticky_unf_o(s_unf)
    );

    exp_operation_pipe #(.EW(8), .BIAS(127), .SAT(1'b0)) dut_nosat (
        .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(ns_in_ready),
        .op_mode_i(op_mode), .Data_A_i(a), .Data_B_i(b),
        .out_valid_o(ns_out_valid), .out_ready_i(out_ready), .Data_Result_o(ns_res),
        .Overflow_flag_o(ns_ovf), .Underflow_flag_o(ns_unf), .sticky_clr_i(sticky_clr),
        .Sticky_ovf_o(ns_s_ovf), .Sticky_unf_o(ns_s_unf)
    );

    always #5 clk = ~clk;

    // Directed vectors; expected values worked out by hand.
    int v_mode[13] = '{2, 2, 3, 1, 0, 1, 0, 0, 2, 1, 2, 0, 0};
    int v_a[13]    = '{130, 200, 10, 5, 100, 200, 255, 254, 127, 3, 200, 1, 3};
    int v_b[13]    = '{125, 200, 200, 5, 50, 20, 0, 0, 1, 7, 200, 2, 4};
    int e_res[13]  = '{128, 255, 0, 0, 150, 180, 255, 254, 1, 0, 255, 3, 7};
    int e_ns[13]   = '{128, 17, 193, 0, 150, 180, 255, 254, 1, 252, 17, 3, 7};
    int e_ovf[13]  = '{0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0};
    int e_unf[13]  = '{0, 0, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0};

    typedef struct {
        int idx;
        int res;
        int res_ns;
        int ovf;
        int unf;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    bit   in_ready_low_seen = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Present vector idx until accepted; optionally queue its expected result.
    task automatic send(input int idx, input bit expect_out);
        exp_t e;
        int   v;
        @(negedge clk);
        in_valid = 1'b1;
        v = v_mode[idx];
        op_mode = v[1:0];
        a = 8'(v_a[idx]);
        b = 8'(v_b[idx]);
        for (int n = 0; n < 60; n++) begin
            #1;
            if (in_ready) break;
            in_ready_low_seen = 1'b1;
            if (n == 59) begin
                check("accept_timeout", 0, 1);
                break;
            end
            @(negedge clk);
        end
        if (expect_out) begin
            e.idx = idx; e.res = e_res[idx]; e.res_ns = e_ns[idx];
            e.ovf = e_ovf[idx]; e.unf = e_unf[idx];
            sb.push_back(e);
        end
        @(posedge clk);
    endtask

    // Monitor: compares every handoff against the scoreboard and checks that
    // a stalled output does not change.
    initial begin
        exp_t e;
        bit   held = 1'b0;
        int   h_res = 0, h_ovf = 0, h_unf = 0;
        forever begin
            @(negedge clk);
            #2;
            if (rst || !out_valid) begin
                held = 1'b0;
            end else if (out_ready) begin
                held = 1'b0;
                check("twin_valid", int'(ns_out_valid), 1);
                if (sb.size() == 0) begin
                    check("unexpected_output", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check($sformatf("res[%0d]", e.idx), int'(res), e.res);
                    check($sformatf("res_nosat[%0d]", e.idx), int'(ns_res), e.res_ns);
                    check($sformatf("ovf[%0d]", e.idx), int'(ovf), e.ovf);
                    check($sformatf("unf[%0d]", e.idx), int'(unf), e.unf);
                end
            end else begin
                if (held) begin
                    check("stall_res", int'(res), h_res);
                    check("stall_ovf", int'(ovf), h_ovf);
                    check("stall_unf", int'(unf), h_unf);
                end
                held = 1'b1;
                h_res = int'(res); h_ovf = int'(ovf); h_unf = int'(unf);
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #3;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_result", int'(res), 0);
        check("rst_sticky_ovf", int'(s_ovf), 0);
        check("rst_sticky_unf", int'(s_unf), 0);

        // Latency: valid appears on the second edge after accept.
        send(0, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        #1 check("latency_edge1", int'(out_valid), 0);
        @(negedge clk);
        #1 check("latency_edge2", int'(out_valid), 1);

        send(1, 1'b1);
        send(2, 1'b1);
        send(3, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        #3;
        check("sticky_ovf_set", int'(s_ovf), 1);
        check("sticky_unf_set", int'(s_unf), 1);

        // Stream of six with a three-cycle consumer stall mid-stream.
        in_ready_low_seen = 1'b0;
        fork
            begin
                for (int i = 4; i < 10; i++) send(i, 1'b1);
                @(negedge clk);
                in_valid = 1'b0;
                a = 8'hAA; b = 8'h55;
            end
            begin
                repeat (3) @(negedge clk);
                out_ready = 1'b0;
                repeat (3) @(negedge clk);
                out_ready = 1'b1;
            end
        join
        check("in_ready_drop", int'(in_ready_low_seen), 1);
        for (int n = 0; n < 50 && sb.size() != 0; n++) @(negedge clk);
        check("stream_drained", sb.size(), 0);

        @(negedge clk);
        sticky_clr = 1'b1;
        @(negedge clk);
        sticky_clr = 1'b0;
        #3;
        check("clear_ovf", int'(s_ovf), 0);
        check("clear_unf", int'(s_unf), 0);

        // Clear in the same cycle as an overflow handoff: set wins.
        out_ready = 1'b0;
        send(10, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        out_ready = 1'b1;
        sticky_clr = 1'b1;
        @(negedge clk);
        sticky_clr = 1'b0;
        #3;
        check("clr_vs_set_ovf", int'(s_ovf), 1);
        sticky_clr = 1'b1;
        @(negedge clk);
        sticky_clr = 1'b0;
        #3;
        check("clr_again_ovf", int'(s_ovf), 0);

        // Reset with two transactions in flight.
        send(1, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        #3 check("sticky_pre_rst", int'(s_ovf), 1);
        out_ready = 1'b0;
        send(11, 1'b0);
        send(12, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #3;
        check("inflight_rst_valid", int'(out_valid), 0);
        check("inflight_rst_ready", int'(in_ready), 1);
        check("inflight_rst_sovf", int'(s_ovf), 0);
        check("inflight_rst_sunf", int'(s_unf), 0);
        out_ready = 1'b1;
        repeat (8) @(negedge clk);
        #3 check("post_rst_quiet", int'(out_valid), 0);
        check("scoreboard_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
